// File: rtl/ddr3_pkg.sv
// ddr3_pkg: command encodings, error codes and monitor states shared by the DDR3 command monitor.
package ddr3_pkg;
    typedef enum logic [2:0] {
        CMD_MRS = 3'b000, CMD_REF = 3'b001, CMD_PRE = 3'b010, CMD_ACT = 3'b011,
        CMD_WR  = 3'b100, CMD_RD  = 3'b101, CMD_ZQC = 3'b110, CMD_NOP = 3'b111
    } cmd_e;

    typedef enum logic [2:0] {
        ERR_NONE = 3'd0, ERR_ORDER = 3'd1, ERR_TMRD = 3'd2, ERR_TMOD = 3'd3,
        ERR_ACT_OPEN = 3'd4, ERR_CLOSED = 3'd5, ERR_ZQ_BUSY = 3'd6, ERR_REF_OPEN = 3'd7
    } err_e;

    typedef enum logic [2:0] {
        ST_WAIT_CKE, ST_MRS_SEQ, ST_WAIT_ZQ, ST_ZQ_BUSY, ST_READY
    } state_e;

    // Init programs the mode registers in the order MR2, MR3, MR1, MR0.
    function automatic logic [2:0] mrs_expect(input logic [1:0] idx);
        return idx == 2'd0 ? 3'd2 : idx == 2'd1 ? 3'd3 : idx == 2'd2 ? 3'd1 : 3'd0;
    endfunction
endpackage

// File: rtl/ddr3_bank_tracker.sv
// ddr3_bank_tracker: per-bank open flags with a hit flag for the addressed bank.
module ddr3_bank_tracker (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_act,
    input  logic       i_pre,
    input  logic       i_pre_all,
    input  logic [2:0] i_ba,
    output logic [7:0] o_bank_open,
    output logic       o_hit
);
    logic [7:0] r_open;

    always_ff @(posedge clk or posedge rst)
        if (rst)
            r_open <= '0;
        else if (i_pre_all)
            r_open <= '0;
        else if (i_act)
            r_open[i_ba] <= 1'b1;
        else if (i_pre)
            r_open[i_ba] <= 1'b0;

    assign o_bank_open = r_open;
    assign o_hit       = r_open[i_ba];
endmodule

// File: rtl/ddr3_cmd_monitor.sv
// ddr3_cmd_monitor: registers the DDR3 command bus, decodes commands, tracks init/mode/bank
// state and reports the highest-priority protocol violation per command.
module ddr3_cmd_monitor
    import ddr3_pkg::*;
#(
    parameter int TMRD    = 4,
    parameter int TMOD    = 12,
    parameter int TZQINIT = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_cke,
    input  logic        i_cs_n,
    input  logic        i_ras_n,
    input  logic        i_cas_n,
    input  logic        i_we_n,
    input  logic [2:0]  i_ba,
    input  logic [12:0] i_addr,
    output logic        o_cmd_valid,
    output logic [2:0]  o_cmd_code,
    output logic [12:0] o_mr0,
    output logic [12:0] o_mr1,
    output logic [12:0] o_mr2,
    output logic [12:0] o_mr3,
    output logic [7:0]  o_bank_open,
    output logic        o_init_done,
    output logic        o_err_valid,
    output logic [2:0]  o_err_code,
    output logic [7:0]  o_err_count
);
    localparam int ZW = $clog2(TZQINIT + 1);

    logic             r_cke, r_cs_n;
    logic [2:0]       r_cmd, r_ba;
    logic [12:0]      r_addr;
    state_e           r_state, w_state_nxt;
    logic [1:0]       r_seq;
    logic [9:0]       r_gap;
    logic [ZW-1:0]    r_zq;
    logic [3:0][12:0] r_mr;
    logic             w_live, w_mrs, w_busy, w_ready, w_seq_ok, w_zqcl, w_order, w_hit;
    logic             w_act, w_rdwr, w_ref, w_pre;
    logic [2:0]       w_err;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_cke  <= 1'b0;
            r_cs_n <= 1'b1;
            r_cmd  <= CMD_NOP;
            r_ba   <= '0;
            r_addr <= '0;
        end else begin
            r_cke  <= i_cke;
            r_cs_n <= i_cs_n;
            r_cmd  <= {i_ras_n, i_cas_n, i_we_n};
            r_ba   <= i_ba;
            r_addr <= i_addr;
        end

    assign w_live   = r_cke && !r_cs_n && r_cmd != CMD_NOP;
    assign w_mrs    = w_live && r_cmd == CMD_MRS;
    assign w_act    = w_live && r_cmd == CMD_ACT;
    assign w_pre    = w_live && r_cmd == CMD_PRE;
    assign w_ref    = w_live && r_cmd == CMD_REF;
    assign w_rdwr   = w_live && (r_cmd == CMD_RD || r_cmd == CMD_WR);
    assign w_busy   = r_state == ST_ZQ_BUSY;
    assign w_ready  = r_state == ST_READY;
    assign w_seq_ok = r_state == ST_MRS_SEQ && r_ba == mrs_expect(r_seq);
    assign w_zqcl   = w_live && r_cmd == CMD_ZQC && r_addr[10] && r_state == ST_WAIT_ZQ;
    assign w_order  = w_live && !w_ready && (w_mrs ? !w_seq_ok : !w_zqcl);

    // A command k cycles after an MRS sees r_gap == k-1, hence the -1 on both limits.
    assign w_err = !w_live                               ? ERR_NONE     :
                   w_busy                                ? ERR_ZQ_BUSY  :
                   w_order                               ? ERR_ORDER    :
                   w_mrs && r_gap < 10'(TMRD - 1)        ? ERR_TMRD     :
                   !w_mrs && r_gap < 10'(TMOD - 1)       ? ERR_TMOD     :
                   w_act && w_hit                        ? ERR_ACT_OPEN :
                   w_rdwr && !w_hit                      ? ERR_CLOSED   :
                   w_ref && o_bank_open != '0            ? ERR_REF_OPEN : ERR_NONE;

    ddr3_bank_tracker u_banks (
        .clk         (clk),
        .rst         (rst),
        .i_act       (w_act && w_ready),
        .i_pre       (w_pre && w_ready && !r_addr[10]),
        .i_pre_all   (w_pre && w_ready && r_addr[10]),
        .i_ba        (r_ba),
        .o_bank_open (o_bank_open),
        .o_hit       (w_hit)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst)
            r_state <= ST_WAIT_CKE;
        else
            r_state <= w_state_nxt;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_WAIT_CKE: w_state_nxt = r_cke ? ST_MRS_SEQ : ST_WAIT_CKE;
            ST_MRS_SEQ:  w_state_nxt = w_mrs && w_seq_ok && r_seq == 2'd3 ? ST_WAIT_ZQ : ST_MRS_SEQ;
            ST_WAIT_ZQ:  w_state_nxt = w_zqcl ? ST_ZQ_BUSY : ST_WAIT_ZQ;
            ST_ZQ_BUSY:  w_state_nxt = r_zq <= ZW'(1) ? ST_READY : ST_ZQ_BUSY;
            default:     w_state_nxt = r_state;
        endcase
    end

    always_comb o_init_done = w_ready;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_seq       <= '0;
            r_gap       <= '1;
            r_zq        <= '0;
            r_mr        <= '0;
            o_cmd_valid <= 1'b0;
            o_cmd_code  <= CMD_NOP;
            o_err_valid <= 1'b0;
            o_err_code  <= ERR_NONE;
            o_err_count <= '0;
        end else begin
            r_seq       <= w_mrs && w_seq_ok ? r_seq + 2'd1 : r_seq;
            r_gap       <= w_mrs && !w_busy ? '0 : r_gap != '1 ? r_gap + 10'd1 : r_gap;
            r_zq        <= w_zqcl ? ZW'(TZQINIT) : r_zq != '0 ? r_zq - ZW'(1) : r_zq;
            if (w_mrs && !w_busy && !r_ba[2])
                r_mr[r_ba[1:0]] <= r_addr;
            o_cmd_valid <= w_live;
            o_cmd_code  <= w_live ? r_cmd : CMD_NOP;
            o_err_valid <= w_err != ERR_NONE;
            o_err_code  <= w_err != ERR_NONE ? w_err : o_err_code;
            o_err_count <= w_err != ERR_NONE && o_err_count != 8'hFF ? o_err_count + 8'd1 : o_err_count;
        end

    assign o_mr0 = r_mr[0];
    assign o_mr1 = r_mr[1];
    assign o_mr2 = r_mr[2];
    assign o_mr3 = r_mr[3];
endmodule

// File: tb/tb_ddr3_cmd_monitor.sv
// tb_ddr3_cmd_monitor: scoreboard bench; each issued command queues its expected code/error,
// which are popped when the monitor reports the decoded command.
module tb_ddr3_cmd_monitor;
    localparam logic [2:0] MRS = 3'b000, REF = 3'b001, PRE = 3'b010, ACT = 3'b011;
    localparam logic [2:0] WR = 3'b100, RD = 3'b101, ZQC = 3'b110, NOP = 3'b111;

    typedef struct {
        logic [2:0] cmd;
        logic [2:0] err;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        cke = 1'b0, cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
    logic [2:0]  ba = '0;
    logic [12:0] addr = '0;
    logic        cmd_valid, init_done, err_valid;
    logic [2:0]  cmd_code, err_code;
    logic [12:0] mr0, mr1, mr2, mr3;
    logic [7:0]  bank_open, err_count;

    exp_t q[$];
    int   pass_cnt = 0, total_cnt = 0, exp_errs = 0;

    ddr3_cmd_monitor dut (
        .clk(clk), .rst(rst), .i_cke(cke), .i_cs_n(cs_n), .i_ras_n(ras_n), .i_cas_n(cas_n),
        .i_we_n(we_n), .i_ba(ba), .i_addr(addr), .o_cmd_valid(cmd_valid), .o_cmd_code(cmd_code),
        .o_mr0(mr0), .o_mr1(mr1), .o_mr2(mr2), .o_mr3(mr3), .o_bank_open(bank_open),
        .o_init_done(init_done), .o_err_valid(err_valid), .o_err_code(err_code),
        .o_err_count(err_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && cmd_valid) begin
            total_cnt++;
            if (q.size() == 0) begin
                $display("FAIL sb_unexpected: cmd_valid with code %0d, nothing expected", cmd_code);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (cmd_code !== e.cmd || err_valid !== (e.err != 3'd0) ||
                    (e.err != 3'd0 && err_code !== e.err))
                    $display("FAIL sb_cmd: got code %0d err_valid %0b err %0d, want code %0d err %0d",
                             cmd_code, err_valid, err_code, e.cmd, e.err);
                else
                    pass_cnt++;
            end
        end else if (!rst && err_valid) begin
            total_cnt++;
            $display("FAIL sb_err_no_cmd: err_valid without cmd_valid, err %0d", err_code);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic issue(input logic [2:0] c, input logic [2:0] b, input logic [12:0] a,
                         input logic [2:0] e);
        cs_n = 1'b0;
        {ras_n, cas_n, we_n} = c;
        ba = b;
        addr = a;
        q.push_back('{c, e});
        if (e != 3'd0 && exp_errs < 255) exp_errs++;
        @(negedge clk);
        cs_n = 1'b1;
        {ras_n, cas_n, we_n} = NOP;
    endtask

    task automatic drain(input string name);
        int n = 0;
        idle(2);
        while (q.size() != 0 && n < 20) begin
            idle(1);
            n++;
        end
        total_cnt++;
        if (q.size() != 0) begin
            $display("FAIL drain_%s: %0d expected commands never reported, want 0", name, q.size());
            q.delete();
        end else pass_cnt++;
    endtask

    task automatic test_reset;
        idle(2);
        total_cnt++;
        if ({cmd_valid, cmd_code, mr0, mr1, mr2, mr3, bank_open, init_done, err_valid, err_code, err_count}
            !== {1'b0, 3'b111, 52'd0, 8'd0, 1'b0, 1'b0, 3'd0, 8'd0})
            $display("FAIL reset_values: valid %0b code %0d mr0 %h bank %h init %0b err %0b/%0d cnt %0d, want 0 7 0 0 0 0/0 0",
                     cmd_valid, cmd_code, mr0, bank_open, init_done, err_valid, err_code, err_count);
        else pass_cnt++;
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_init;
        cke = 1'b1;
        idle(2);
        issue(MRS, 3'd2, 13'h0008, 3'd0); idle(11);
        issue(MRS, 3'd3, 13'h0000, 3'd0); idle(11);
        issue(MRS, 3'd1, 13'h0044, 3'd0); idle(11);
        issue(MRS, 3'd0, 13'h0A12, 3'd0); idle(11);
        issue(ZQC, 3'd0, 13'h0400, 3'd0);
        idle(500);
        total_cnt++;
        if (init_done !== 1'b0) $display("FAIL init_early: init_done %0b during ZQ_BUSY, want 0", init_done);
        else pass_cnt++;
        idle(20);
        drain("init");
        total_cnt++;
        if ({init_done, mr0, mr1, mr2, err_count} !== {1'b1, 13'h0A12, 13'h0044, 13'h0008, 8'd0})
            $display("FAIL init_done: init %0b mr0 %h mr1 %h mr2 %h errs %0d, want 1 0a12 0044 0008 0",
                     init_done, mr0, mr1, mr2, err_count);
        else pass_cnt++;
    endtask

    task automatic test_banks;
        issue(ACT, 3'd5, 13'h0123, 3'd0); idle(2);
        issue(RD, 3'd5, 13'h0010, 3'd0);
        drain("act_rd");
        total_cnt++;
        if (bank_open !== 8'h20) $display("FAIL bank_act5: bank_open %h, want 20", bank_open);
        else pass_cnt++;
        issue(RD, 3'd2, 13'h0000, 3'd5);
        issue(ACT, 3'd5, 13'h0456, 3'd4);
        drain("closed_actopen");
        total_cnt++;
        if (bank_open !== 8'h20) $display("FAIL bank_reopen: bank_open %h, want 20", bank_open);
        else pass_cnt++;
        issue(PRE, 3'd5, 13'h0000, 3'd0);
        drain("pre5");
        total_cnt++;
        if (bank_open !== 8'h00) $display("FAIL bank_pre5: bank_open %h, want 00", bank_open);
        else pass_cnt++;
        issue(ACT, 3'd0, 13'h0001, 3'd0);
        issue(ACT, 3'd1, 13'h0002, 3'd0);
        drain("act01");
        total_cnt++;
        if (bank_open !== 8'h03) $display("FAIL bank_act01: bank_open %h, want 03", bank_open);
        else pass_cnt++;
        issue(PRE, 3'd6, 13'h0400, 3'd0);
        drain("preall");
        total_cnt++;
        if (bank_open !== 8'h00) $display("FAIL bank_preall: bank_open %h, want 00", bank_open);
        else pass_cnt++;
        issue(ACT, 3'd3, 13'h0003, 3'd0);
        issue(REF, 3'd0, 13'h0000, 3'd7);
        drain("ref_open");
        total_cnt++;
        if (bank_open !== 8'h08 || err_count !== 8'(exp_errs))
            $display("FAIL ref_open: bank_open %h errs %0d, want 08 %0d", bank_open, err_count, exp_errs);
        else pass_cnt++;
        issue(PRE, 3'd0, 13'h0400, 3'd0);
    endtask

    task automatic test_back_to_back;
        issue(ACT, 3'd2, 13'h0100, 3'd0);
        issue(WR, 3'd2, 13'h0008, 3'd0);
        issue(RD, 3'd2, 13'h0008, 3'd0);
        issue(RD, 3'd4, 13'h0008, 3'd5);
        issue(PRE, 3'd2, 13'h0000, 3'd0);
        issue(ZQC, 3'd0, 13'h0000, 3'd0);
        drain("b2b");
        total_cnt++;
        if (bank_open !== 8'h00 || err_code !== 3'd5)
            $display("FAIL b2b_state: bank_open %h err_code %0d, want 00 5", bank_open, err_code);
        else pass_cnt++;
    endtask

    task automatic test_timing;
        idle(12);
        issue(MRS, 3'd1, 13'h0004, 3'd0); idle(1);
        issue(MRS, 3'd1, 13'h0006, 3'd2); idle(4);
        issue(ACT, 3'd6, 13'h0077, 3'd3); idle(20);
        issue(MRS, 3'd2, 13'h0010, 3'd0); idle(3);
        issue(MRS, 3'd2, 13'h0018, 3'd0); idle(11);
        issue(PRE, 3'd0, 13'h0400, 3'd0);
        drain("timing");
        total_cnt++;
        if ({mr1, mr2, bank_open, err_count} !== {13'h0006, 13'h0018, 8'h00, 8'(exp_errs)})
            $display("FAIL timing_state: mr1 %h mr2 %h bank %h errs %0d, want 0006 0018 00 %0d",
                     mr1, mr2, bank_open, err_count, exp_errs);
        else pass_cnt++;
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 260; i++) issue(RD, 3'd7, 13'h0000, 3'd5);
        drain("sat");
        total_cnt++;
        if (err_count !== 8'd255 || exp_errs != 255)
            $display("FAIL err_saturate: err_count %0d, want 255", err_count);
        else pass_cnt++;
    endtask

    task automatic test_order_zq;
        rst = 1'b1;
        cke = 1'b0;
        q.delete();
        exp_errs = 0;
        idle(2);
        rst = 1'b0;
        idle(2);
        cke = 1'b1;
        idle(2);
        issue(MRS, 3'd3, 13'h0055, 3'd1);
        drain("order_mrs");
        total_cnt++;
        if (err_count !== 8'd1 || mr3 !== 13'h0055)
            $display("FAIL order_mrs: err_count %0d mr3 %h, want 1 0055", err_count, mr3);
        else pass_cnt++;
        idle(3);
        issue(ACT, 3'd0, 13'h0000, 3'd1); idle(11);
        issue(MRS, 3'd2, 13'h0000, 3'd0); idle(11);
        issue(MRS, 3'd3, 13'h0000, 3'd0); idle(11);
        issue(MRS, 3'd1, 13'h0000, 3'd0); idle(11);
        issue(MRS, 3'd0, 13'h0321, 3'd0); idle(11);
        issue(ZQC, 3'd0, 13'h0400, 3'd0); idle(9);
        issue(REF, 3'd0, 13'h0000, 3'd6);
        drain("zq_busy");
        total_cnt++;
        if (err_count !== 8'd3 || err_code !== 3'd6 || init_done !== 1'b0)
            $display("FAIL zq_busy_state: errs %0d code %0d init %0b, want 3 6 0", err_count, err_code, init_done);
        else pass_cnt++;
        idle(40);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if ({cmd_valid, cmd_code, mr0, mr1, mr2, mr3, bank_open, init_done, err_valid, err_code, err_count}
            !== {1'b0, 3'b111, 52'd0, 8'd0, 1'b0, 1'b0, 3'd0, 8'd0})
            $display("FAIL async_reset: code %0d mr0 %h mr3 %h err %0d cnt %0d, want 7 0 0 0 0",
                     cmd_code, mr0, mr3, err_code, err_count);
        else pass_cnt++;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        idle(2);
    endtask

    initial begin
        test_reset;
        test_init;
        test_banks;
        test_back_to_back;
        test_timing;
        test_saturation;
        test_order_zq;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
